// File: rtl/nf_uart_pkg.sv
// Shared UART definitions: receiver state encoding, datapath widths and baud helpers.
// The transmitter is expected to import this package as well.
package nf_uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_COMP_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Half a bit period, truncated; marks mid-bit inside the start bit.
  function automatic logic [UART_COMP_W-1:0] half_bit(input logic [UART_COMP_W-1:0] comp);
    return comp >> 1;
  endfunction

endpackage

// File: rtl/nf_uart_sync.sv
// N-flop synchronizer for asynchronous single-bit inputs; resets to 1 (idle-high lines).
// N must be at least 2.
module nf_uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stages <= '1;
    else       stages <= {stages[N-2:0], d};
  end

  assign q = stages[N-1];

endmodule

// File: rtl/nf_uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling driven by a per-frame latched clocks-per-bit value.
// Returns to IDLE at mid stop bit so back-to-back frames are not lost.
import nf_uart_pkg::*;

module nf_uart_receiver #(
  parameter int DATA_W      = UART_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rec_en,
  input  logic [UART_COMP_W-1:0] comp,
  output logic [DATA_W-1:0]      rx_data,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   busy,
  input  logic                   uart_rx
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  rx_state_t              state;
  logic                   rx_s;
  logic [UART_COMP_W-1:0] comp_r;
  logic [UART_COMP_W-1:0] cnt;
  logic [UART_COMP_W-1:0] half;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_W-1:0]      shift_reg;
  logic                   bit_end;

  nf_uart_sync #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_rx),
    .q     (rx_s)
  );

  assign half    = half_bit(comp_r);
  assign bit_end = (cnt == comp_r - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      comp_r    <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (!rec_en) begin
        state   <= IDLE;
        busy    <= 1'b0;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state  <= START;
              busy   <= 1'b1;
              cnt    <= '0;
              comp_r <= comp;
            end
          end
          START: begin
            if (cnt == half) begin
              cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                // Start bit did not survive to mid-bit: treat as line noise.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          DATA: begin
            if (bit_end) begin
              shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
              cnt       <= '0;
              bit_idx   <= bit_idx + 1'b1;
              if (bit_idx == LAST_BIT) state <= STOP;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          STOP: begin
            if (bit_end) begin
              if (rx_s) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nf_uart_receiver.sv
// Scoreboard bench for nf_uart_receiver: a serializer drives 8N1 frames and queues the
// expected outcome; a monitor pops one entry per rx_valid/frame_err pulse.
module tb_nf_uart_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rec_en = 1'b0;
  logic        uart_rx = 1'b1;
  logic [15:0] comp = 16'd434;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        busy;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] last_good = 8'h00;

  always #5 clk = ~clk;

  nf_uart_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .rec_en    (rec_en),
    .comp      (comp),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .uart_rx   (uart_rx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_bit(input logic v, input int len);
    @(negedge clk);
    uart_rx = v;
    repeat (len - 1) @(negedge clk);
  endtask

  task automatic idle_bits(input int nbits, input int len);
    drive_bit(1'b1, nbits * len);
  endtask

  task automatic send_byte(input logic [7:0] b, input int len, input logic stop_val,
                           input logic poke_comp);
    sb.push_back('{err: ~stop_val, data: b});
    drive_bit(1'b0, len);
    if (poke_comp) comp = 16'd200;
    for (int i = 0; i < 8; i++) drive_bit(b[i], len);
    drive_bit(stop_val, len);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rx_valid || frame_err) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("frame_err", {31'd0, frame_err}, {31'd0, e.err});
        check("rx_valid", {31'd0, rx_valid}, {31'd0, ~e.err});
        if (e.err) begin
          check("rx_data_hold", {24'd0, rx_data}, {24'd0, last_good});
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          last_good = e.data;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "time limit expired");
  end

  initial begin
    string hello;
    hello = "Hello World!";

    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    rec_en = 1'b1;
    idle_bits(2, 434);

    // Golden frames 'H', 'i'
    send_byte(8'h48, 434, 1'b1, 1'b0);
    idle_bits(2, 434);
    send_byte(8'h69, 434, 1'b1, 1'b0);
    idle_bits(2, 434);

    // Framing error then recovery
    send_byte(8'hA5, 434, 1'b0, 1'b0);
    idle_bits(1, 434);
    send_byte(8'h5A, 434, 1'b1, 1'b0);
    idle_bits(2, 434);

    // Glitch shorter than half a bit
    drive_bit(1'b0, 100);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    drive_bit(1'b1, 300);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);

    // Back-to-back, then slower baud with a comp change mid-frame
    send_byte(8'h00, 434, 1'b1, 1'b0);
    send_byte(8'hFF, 434, 1'b1, 1'b0);
    idle_bits(1, 434);
    comp = 16'd868;
    idle_bits(1, 868);
    send_byte(8'h3C, 868, 1'b1, 1'b1);
    comp = 16'd868;
    idle_bits(2, 868);

    // Fast-baud string, back-to-back
    comp = 16'd32;
    idle_bits(2, 32);
    for (int i = 0; i < hello.len(); i++) send_byte(hello[i], 32, 1'b1, 1'b0);
    idle_bits(2, 32);
    comp = 16'd434;
    idle_bits(2, 434);

    // Abort after four data bits
    drive_bit(1'b0, 434);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 434);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rec_en = 1'b0;
    uart_rx = 1'b1;
    @(negedge clk);
    check("abort_busy_after", {31'd0, busy}, 32'd0);
    idle_bits(2, 434);
    rec_en = 1'b1;
    idle_bits(1, 434);
    send_byte(8'h81, 434, 1'b1, 1'b0);
    idle_bits(2, 434);

    // Asynchronous reset mid-frame
    drive_bit(1'b0, 434);
    drive_bit(1'b1, 434);
    drive_bit(1'b0, 200);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_rx_data", {24'd0, rx_data}, 32'h00);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("async_frame_err", {31'd0, frame_err}, 32'd0);
    last_good = 8'h00;
    uart_rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_bits(2, 434);
    send_byte(8'hC3, 434, 1'b1, 1'b0);
    idle_bits(2, 434);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
